// File: rtl/restoring_div_core.sv
// restoring_div_core: sequential restoring unsigned divider, iterations limited to dividend MSB+1
module restoring_div_core #(
  parameter int BIT = 16,
  parameter int MW = $clog2(BIT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [BIT-1:0] dividend,
  input  logic [BIT-1:0] divisor,
  input  logic [MW-1:0]  dividend_msb,
  output logic           busy,
  output logic           done,
  output logic [BIT-1:0] quotient,
  output logic [BIT-1:0] remainder,
  output logic           div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [MW:0] BW = (MW+1)'(BIT);
  state_t state;
  logic [BIT-1:0] a, q, d, a_n, q_n;
  logic [MW:0] cnt, k;
  logic [BIT:0] a_sh, t;
  // Partial remainder stays below the divisor, so BIT bits hold it between steps
  always_comb begin
    k = {1'b0, dividend_msb} + (MW+1)'(1);
    a_sh = {a, q[BIT-1]};
    t = a_sh - {1'b0, d};
    a_n = t[BIT] ? a_sh[BIT-1:0] : t[BIT-1:0];
    q_n = {q[BIT-2:0], ~t[BIT]};
  end
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == CALC) begin
      a <= a_n;
      q <= q_n;
      cnt <= cnt - (MW+1)'(1);
      if (cnt == (MW+1)'(1)) begin
        state <= DONE;
        quotient <= q_n;
        remainder <= a_n;
        div_by_zero <= 1'b0;
      end
    end else begin
      state <= !start ? IDLE : (divisor == '0 ? DONE : CALC);
      if (start) begin
        a <= '0;
        q <= dividend << (BW - k);
        d <= divisor;
        cnt <= k;
        if (divisor == '0) begin
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_restoring_div_core.sv
// tb_restoring_div_core: directed vector table plus handshake corner sequences and a random sweep
module tb_restoring_div_core;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic [3:0] dividend_msb = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int n_cmp = 0, n_bad = 0;

  restoring_div_core #(.BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .dividend_msb(dividend_msb), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0] m;
    logic [15:0] eq, er;
    logic ez;
    int lat, bc;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [3:0] m);
    @(negedge clk);
    dividend = a; divisor = b; dividend_msb = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after launch: counts cycles (first post-accept cycle = 1) until done
  task automatic wait_done(output int lat, output int bc);
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  function automatic logic [3:0] msb_of(input logic [15:0] v);
    logic [3:0] r = '0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  vec_t vecs[12];
  int lat, bc, dcnt;
  logic [15:0] ra, rb;

  initial begin
    vecs[0]  = '{16'd100,   16'd7,     4'd6,  16'd14,    16'd2,      1'b0, 8,  7};
    vecs[1]  = '{16'hFFFF,  16'd1,     4'd15, 16'hFFFF,  16'd0,      1'b0, 17, 16};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,  4'd15, 16'd1,     16'd0,      1'b0, 17, 16};
    vecs[3]  = '{16'd5,     16'd0,     4'd2,  16'hFFFF,  16'd5,      1'b1, 1,  0};
    vecs[4]  = '{16'd0,     16'd3,     4'd0,  16'd0,     16'd0,      1'b0, 2,  1};
    vecs[5]  = '{16'd3,     16'd9,     4'd1,  16'd0,     16'd3,      1'b0, 3,  2};
    vecs[6]  = '{16'd1000,  16'd3,     4'd9,  16'd333,   16'd1,      1'b0, 11, 10};
    vecs[7]  = '{16'd200,   16'd9,     4'd7,  16'd22,    16'd2,      1'b0, 9,  8};
    vecs[8]  = '{16'd50,    16'd5,     4'd5,  16'd10,    16'd0,      1'b0, 7,  6};
    vecs[9]  = '{16'd6,     16'd4,     4'd10, 16'd1,     16'd2,      1'b0, 12, 11};
    vecs[10] = '{16'h8000,  16'h8001,  4'd15, 16'd0,     16'h8000,   1'b0, 17, 16};
    vecs[11] = '{16'd12345, 16'd123,   4'd13, 16'd100,   16'd45,     1'b0, 15, 14};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].m);
      wait_done(lat, bc);
      chk($sformatf("v%0d_quot", i), quotient, vecs[i].eq);
      chk($sformatf("v%0d_rem", i), remainder, vecs[i].er);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].ez);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].bc);
    end

    // Start pulsed mid-CALC must be ignored
    launch(16'd200, 16'd9, 4'd7);
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        dividend = 16'd50; divisor = 16'd5; dividend_msb = 4'd5; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ign_quot", quotient, 22);
    chk("ign_rem", remainder, 2);
    chk("ign_lat", lat, 9);

    // Back-to-back start on the done cycle; old results held while busy
    dividend = 16'd50; divisor = 16'd5; dividend_msb = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_hold_quot", quotient, 22);
    chk("b2b_busy", busy, 1);
    wait_done(lat, bc);
    chk("b2b_lat", lat, 7);
    chk("b2b_quot", quotient, 10);
    chk("b2b_rem", remainder, 0);

    // Reset at busy cycle 4 discards the operation
    launch(16'd1000, 16'd3, 4'd9);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_quot", quotient, 0);
    chk("mrst_rem", remainder, 0);
    chk("mrst_dbz", div_by_zero, 0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    chk("mrst_no_done", dcnt, 0);
    launch(16'd1000, 16'd3, 4'd9);
    wait_done(lat, bc);
    chk("mrst_again_quot", quotient, 333);
    chk("mrst_again_rem", remainder, 1);

    // Random sweep with the true MSB supplied
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom()) >> $urandom_range(0, 15);
      rb = 16'($urandom_range(1, 65535)) >> $urandom_range(0, 15);
      if (rb == '0) rb = 16'd1;
      launch(ra, rb, msb_of(ra));
      wait_done(lat, bc);
      chk($sformatf("rnd%0d_quot(%0d/%0d)", i, ra, rb), quotient, ra / rb);
      chk($sformatf("rnd%0d_rem(%0d%%%0d)", i, ra, rb), remainder, ra % rb);
      chk($sformatf("rnd%0d_lat", i), lat, int'(msb_of(ra)) + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/restoring_div_core.md
# restoring_div_core

Sequential restoring divider for unsigned BIT-wide operands. It sits directly downstream of the leading-one/size detector and consumes that stage's dividend MSB position. Only MSB+1 iterations run, so leading zeros are skipped and latency scales with the dividend's magnitude. A start/done handshake connects it to the control logic.

## Interface
- BIT, 16, operand width (quotient/remainder width); must be ≥ 2
- MW, $clog2(BIT), width of the MSB-position input
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when busy = 0
- dividend  input  BIT  unsigned dividend, sampled on accepted start
- divisor  input  BIT  unsigned divisor, sampled on accepted start
- dividend_msb  input  MW  index of highest set bit of dividend from the size stage (0 when dividend = 0), sampled on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse: results valid
- quotient  output  BIT  unsigned quotient, held until next accepted start
- remainder  output  BIT  unsigned remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor = 0, held with results

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE + start: capture operands. Set k = dividend_msb + 1 and s = BIT − k. Load Q = dividend << s, A (BIT+1 bits) = 0, D = divisor, cnt = k.
  - divisor ≠ 0: go to CALC.
  - divisor = 0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- CALC, each cycle:
  - {A,Q} <<= 1.
  - T = A − {0,D}.
  - If T[BIT] = 0 (non-negative): A = T and Q[0] = 1. Otherwise keep A (restore) and Q[0] = 0.
  - cnt−−. When cnt reaches 0, go to DONE.
- After k steps, Q holds the exact quotient (pre-shifted zero bits end in the high positions) and A[BIT-1:0] holds the remainder.
- DONE: done = 1 for exactly one cycle and results are driven. Next state is IDLE, or CALC/DONE if start is asserted in this cycle (back-to-back allowed).
- start while busy = 1: ignored; in-flight operation unaffected.
- dividend_msb below the true MSB is an upstream contract violation and the result is unspecified. A value above the true MSB only adds iterations and the result stays correct.
- All arithmetic is unsigned. Internal subtraction is BIT+1 bits wide, so no overflow occurs.

## Timing
- Reset (rst_n = 0 at a clk edge), from any state including mid-CALC: state = IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0. The in-flight operation is discarded.
- Start accepted at edge T:
  - busy = 1 from T+1 through T+k.
  - done pulses in cycle T+k+1.
  - Latency is k+1 cycles (2 to BIT+1).
- Divide by zero: busy stays 0 and done pulses at T+1.
- Outputs are registered, with no combinational path from inputs to outputs.
- quotient/remainder/div_by_zero change only at reset or when entering DONE.

## Test plan
- dividend 100, divisor 7, msb 6 -> 7 busy cycles, done 8 cycles after start, quotient 14, remainder 2, div_by_zero 0.
- dividend 0xFFFF, divisor 1, msb 15 -> done 17 cycles after start, quotient 0xFFFF, remainder 0. dividend 0xFFFF, divisor 0xFFFF -> quotient 1, remainder 0.
- dividend 5, divisor 0, msb 2 -> done 1 cycle after start, div_by_zero 1, quotient 0xFFFF, remainder 5, busy never high.
- dividend 0, divisor 3, msb 0 -> done 2 cycles after start, quotient 0, remainder 0. dividend 3, divisor 9, msb 1 -> quotient 0, remainder 3.
- Start 200/9 (msb 7), start pulsed again mid-CALC with 50/5 -> second start ignored, result 22 r 2. Start 50/5 (msb 5) on the done cycle -> accepted, quotient 10, remainder 0 after 7 cycles.
- Start 1000/3 (msb 9), rst_n low for 1 cycle at busy cycle 4 -> next cycle IDLE, all outputs 0, no done pulse. A subsequent 1000/3 yields 333 r 1.
- Randomized sweep (BIT = 16, true msb supplied), compared against a / b and a % b.
